envelope_sequencer: RTL and testbench

- Per-voice dynamics controller. Sequences one note through an attack/decay/sustain/release envelope.
- Advances one step per audio sample tick and outputs an 8-bit gain level for the harmonics mixer.
- Uses the shared sustain-length lookup, a registered note-to-count datapath with fixed latency, to get the sustain duration in samples. It drives the lookup's note input and captures the count after the pipeline has filled.

---
 rtl/envelope_sequencer.sv | 149 ++++++++++++++
 tb/tb_envelope_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_sequencer.sv
// Per-voice attack/decay/sustain/release envelope. One step per sample tick;
// the sustain length comes from an external fixed-latency note-to-count lookup.
module envelope_sequencer #(
  parameter int unsigned ATTACK_STEP    = 32,
  parameter int unsigned DECAY_STEP     = 8,
  parameter int unsigned SUSTAIN_LEVEL  = 128,
  parameter int unsigned RELEASE_STEP   = 4,
  parameter int unsigned LOOKUP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_start,
  input  logic [5:0]  note_in,
  input  logic        note_off,
  input  logic        sample_tick,
  output logic [5:0]  lookup_note,
  input  logic [15:0] lookup_count,
  output logic [7:0]  level,
  output logic        active,
  output logic        done
);

  localparam int unsigned LAT_W = $clog2(LOOKUP_LATENCY + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t           state, state_n;
  logic [7:0]       level_n;
  logic [5:0]       note_n;
  logic [15:0]      sus_cnt, sus_cnt_n;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
  logic             done_n;

  logic       start_note;
  logic       release_req;
  logic [9:0] attack_sum;

  assign start_note  = note_start && (note_in != '0);
  assign release_req = note_off || (note_start && (note_in == '0));
  assign attack_sum  = {2'b00, level} + 10'(ATTACK_STEP);

  always_comb begin
    state_n   = state;
    level_n   = level;
    note_n    = lookup_note;
    sus_cnt_n = sus_cnt;
    lat_cnt_n = lat_cnt;
    done_n    = 1'b0;

    if (start_note) begin
      // Retrigger keeps the current level so the next attack resumes without a click.
      note_n    = note_in;
      lat_cnt_n = LAT_W'(LOOKUP_LATENCY);
      state_n   = LOOKUP;
    end else if (release_req &&
                 (state inside {LOOKUP, ATTACK, DECAY, SUSTAIN})) begin
      state_n = RELEASE;
    end else begin
      case (state)
        IDLE: ;

        LOOKUP: begin
          // The count is sampled one clock after the counter reaches zero,
          // once the lookup pipeline has caught up with lookup_note.
          if (lat_cnt == '0) begin
            sus_cnt_n = lookup_count;
            state_n   = ATTACK;
          end else begin
            lat_cnt_n = lat_cnt - LAT_W'(1);
          end
        end

        ATTACK: begin
          if (sample_tick) begin
            if (attack_sum >= 10'd255) begin
              level_n = '1;
              state_n = DECAY;
            end else begin
              level_n = attack_sum[7:0];
            end
          end
        end

        DECAY: begin
          if (sample_tick) begin
            if ({2'b00, level} <= 10'(SUSTAIN_LEVEL + DECAY_STEP)) begin
              level_n = 8'(SUSTAIN_LEVEL);
              state_n = (sus_cnt == '0) ? RELEASE : SUSTAIN;
            end else begin
              level_n = level - 8'(DECAY_STEP);
            end
          end
        end

        SUSTAIN: begin
          if (sample_tick) begin
            if (sus_cnt <= 16'd1) begin
              state_n = RELEASE;
            end else begin
              sus_cnt_n = sus_cnt - 16'd1;
            end
          end
        end

        RELEASE: begin
          if (sample_tick) begin
            if ({2'b00, level} <= 10'(RELEASE_STEP)) begin
              level_n = '0;
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              level_n = level - 8'(RELEASE_STEP);
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      level       <= '0;
      lookup_note <= '0;
      sus_cnt     <= '0;
      lat_cnt     <= '0;
      active      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      lookup_note <= note_n;
      sus_cnt     <= sus_cnt_n;
      lat_cnt     <= lat_cnt_n;
      active      <= (state_n != IDLE);
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: directed scenarios plus random stimulus, all
// compared every clock against a behavioural envelope model.
module tb_envelope_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        note_start = 1'b0;
  logic [5:0]  note_in = '0;
  logic        note_off = 1'b0;
  logic        sample_tick = 1'b0;
  logic [5:0]  lookup_note;
  logic [15:0] lookup_count;
  logic [7:0]  level;
  logic        active;
  logic        done;

  logic [15:0] pipe1 = '0;
  logic [15:0] pipe2 = '0;

  always #5 clk = ~clk;

  function automatic int lut(int n);
    return (63 - n) * 50;
  endfunction

  // Two-register stub of the shared sustain-length lookup.
  always @(posedge clk) begin
    pipe1 <= 16'(lut(int'(lookup_note)));
    pipe2 <= pipe1;
  end
  assign lookup_count = pipe2;

  envelope_sequencer #(
    .ATTACK_STEP(32),
    .DECAY_STEP(8),
    .SUSTAIN_LEVEL(128),
    .RELEASE_STEP(4),
    .LOOKUP_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .note_start(note_start),
    .note_in(note_in),
    .note_off(note_off),
    .sample_tick(sample_tick),
    .lookup_note(lookup_note),
    .lookup_count(lookup_count),
    .level(level),
    .active(active),
    .done(done)
  );

  typedef enum {P_IDLE, P_WAIT, P_RISE, P_FALL, P_HOLD, P_FADE} phase_t;
  phase_t m_phase;
  int     m_level, m_note, m_hold, m_cyc, m_capture;
  bit     m_done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_level = 0;
    m_note  = 0;
    m_hold  = 0;
    m_done  = 0;
  endtask

  task automatic model_step(bit ns, int ni, bit no, bit tk);
    bit rest;
    m_done = 0;
    rest = no || (ns && ni == 0);
    if (ns && ni != 0) begin
      m_note    = ni;
      m_phase   = P_WAIT;
      m_capture = m_cyc + LAT + 1;
    end else if (rest && m_phase inside {P_WAIT, P_RISE, P_FALL, P_HOLD}) begin
      m_phase = P_FADE;
    end else if (m_phase == P_WAIT) begin
      if (m_cyc == m_capture) begin
        m_hold  = lut(m_note);
        m_phase = P_RISE;
      end
    end else if (tk) begin
      case (m_phase)
        P_RISE: begin
          m_level = m_level + 32;
          if (m_level >= 255) begin m_level = 255; m_phase = P_FALL; end
        end
        P_FALL: begin
          if (m_level - 8 <= 128) begin
            m_level = 128;
            m_phase = (m_hold == 0) ? P_FADE : P_HOLD;
          end else m_level = m_level - 8;
        end
        P_HOLD: begin
          if (m_hold <= 1) m_phase = P_FADE;
          else m_hold = m_hold - 1;
        end
        P_FADE: begin
          if (m_level <= 4) begin
            m_level = 0; m_phase = P_IDLE; m_done = 1;
          end else m_level = m_level - 4;
        end
        default: ;
      endcase
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check("level", int'(level), m_level);
    check("active", int'(active), int'(m_phase != P_IDLE));
    check("done", int'(done), int'(m_done));
    check("lookup_note", int'(lookup_note), m_note);
  endtask

  task automatic cycle(bit ns, int ni, bit no, bit tk);
    note_start  = ns;
    note_in     = 6'(ni);
    note_off    = no;
    sample_tick = tk;
    @(posedge clk);
    model_step(ns, ni, no, tk);
    #1;
    if (done) done_seen++;
    compare_all();
    note_start = 1'b0;
    note_off   = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  int d0;

  initial begin
    m_cyc = 0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Full envelope, note 13 -> 2500 sustain ticks.
    d0 = done_seen;
    cycle(1, 13, 0, 1);
    check("lk_note13", int'(lookup_note), 13);
    ticks(2);
    check("lookup_level_hold", int'(level), 0);
    ticks(1);
    ticks(7);
    check("attack_7", int'(level), 224);
    ticks(1);
    check("attack_peak", int'(level), 255);
    ticks(16);
    check("decay_floor", int'(level), 128);
    ticks(2500);
    check("sustain_end_level", int'(level), 128);
    check("sustain_no_done", done_seen - d0, 0);
    ticks(1);
    check("release_first", int'(level), 124);
    ticks(30);
    check("release_31", int'(level), 4);
    ticks(1);
    check("done_pulse", int'(done), 1);
    check("active_drop", int'(active), 0);
    ticks(1);
    check("done_single", int'(done), 0);
    check("done_once", done_seen - d0, 1);

    // note_off during sustain.
    cycle(1, 62, 0, 1);
    ticks(3 + 8 + 16 + 5);
    cycle(0, 0, 1, 1);
    check("noteoff_hold", int'(level), 128);
    ticks(1);
    check("noteoff_rel1", int'(level), 124);
    ticks(31);
    check("noteoff_done", int'(done), 1);

    // Retrigger mid-decay.
    cycle(1, 60, 0, 1);
    ticks(3 + 8 + 6);
    check("pre_retrig", int'(level), 207);
    cycle(1, 40, 0, 1);
    ticks(2);
    check("retrig_hold", int'(level), 207);
    ticks(1);
    ticks(1);
    check("retrig_atk1", int'(level), 239);
    ticks(1);
    check("retrig_atk2", int'(level), 255);
    cycle(0, 0, 1, 0);
    ticks(70);

    // Zero sustain count skips SUSTAIN.
    cycle(1, 63, 0, 1);
    ticks(3 + 8 + 16);
    check("zero_cnt_level", int'(level), 128);
    ticks(1);
    check("zero_cnt_release", int'(level), 124);
    ticks(40);

    // Start and off together from idle; reset mid-attack; rest while idle.
    d0 = done_seen;
    cycle(1, 50, 1, 0);
    check("start_wins", int'(active), 1);
    ticks(5);
    do_reset();
    check("rst_level", int'(level), 0);
    check("rst_no_done", done_seen - d0, 0);
    cycle(1, 0, 0, 1);
    check("rest_idle", int'(active), 0);

    // Random stimulus.
    for (int i = 0; i < 6000; i++) begin
      bit ns, no, tk;
      int ni;
      if ($urandom_range(0, 2999) == 0) begin
        do_reset();
      end else begin
        ns = ($urandom_range(0, 99) < 2);
        ni = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(56, 63));
        no = ($urandom_range(0, 199) == 0);
        tk = ($urandom_range(0, 2) != 0);
        cycle(ns, ni, no, tk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
